lock_key_loader: RTL and testbench

- Sequences key loading into the key-controlled MUX inputs D_0..D_7 of the locked c17 netlist.
- Accepts a serial key stream through a valid/ready handshake, stages it in a shadow register, then commits it atomically to the key bus.
- After commit, freezes the key until reset, so the locked datapath never sees a partially loaded key.
- Sits between the configuration/test port and the locked netlist's key inputs.

---
 rtl/lock_key_loader.sv | 122 ++++++++++++
 tb/tb_lock_key_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c17 netlist: shadow-shifts KEY_W bits,
// commits them atomically, then freezes. Optional macro: LOCK_KEY_PARITY_EN.
module lock_key_loader #(
   parameter int KEY_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             key_bit_in,
   input  logic             key_bit_valid,
   output logic             key_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [KEY_W-1:0]   key_out_q, key_out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               key_valid_q, key_valid_d;
   logic               key_ready_q, key_ready_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic               accept;

   assign accept = key_bit_valid & key_ready_q;

   // Next state, shadow shifting, commit and registered status outputs
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      key_out_d   = key_out_q;
      cnt_d       = cnt_q;
      key_valid_d = key_valid_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d  = SHIFT;
               shadow_d = '0;
               cnt_d    = '0;
            end
         end
         SHIFT: begin
            // restart wins over a coincident bit; that bit is dropped
            if (load_start) begin
               err_d    = 1'b1;
               shadow_d = '0;
               cnt_d    = '0;
            end else if (accept) begin
`ifdef LOCK_KEY_PARITY_EN
               if (cnt_q == CNT_W'(KEY_W)) begin
                  if (key_bit_in == ^shadow_q) begin
                     state_d = COMMIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  shadow_d = shadow_q | (KEY_W'(key_bit_in) << cnt_q);
                  cnt_d    = cnt_q + 1'b1;
               end
`else
               shadow_d = shadow_q | (KEY_W'(key_bit_in) << cnt_q);
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(KEY_W - 1)) begin
                  state_d = COMMIT;
               end
`endif
            end
         end
         COMMIT: begin
            key_out_d   = shadow_q;
            key_valid_d = 1'b1;
            state_d     = LOCKED;
         end
         LOCKED: begin
            if (load_start) begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      key_ready_d = (state_d == SHIFT);
      busy_d      = (state_d == SHIFT) || (state_d == COMMIT);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shadow_q    <= '0;
         cnt_q       <= '0;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign key_ready = key_ready_q;
   assign key_out   = key_out_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Scoreboard bench for lock_key_loader: expected keys are queued when a
// load starts and compared when key_valid rises.
module tb_lock_key_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_start;
   logic       key_bit_in;
   logic       key_bit_valid;
   logic       key_ready;
   logic [7:0] key_out;
   logic       key_valid;
   logic       busy;
   logic       err;

   int         errors = 0;
   int         checks = 0;
   int         cyc_n = 0;
   int         t_start;
   int         err_cnt;
   bit         early_nz;
   logic [7:0] sb[$];

`ifdef LOCK_KEY_PARITY_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 10;
`endif

   lock_key_loader #(.KEY_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .load_start(load_start),
      .key_bit_in(key_bit_in), .key_bit_valid(key_bit_valid),
      .key_ready(key_ready), .key_out(key_out), .key_valid(key_valid),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic cyc();
      @(posedge clk);
      #1;
      if (err) err_cnt++;
      if (!key_valid && key_out !== 8'h00) early_nz = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1; load_start = 1'b0;
      key_bit_in = 1'b0; key_bit_valid = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      err_cnt = 0; early_nz = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      t_start = cyc_n;
      cyc();
      load_start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      key_bit_valid = 1'b1; key_bit_in = b;
      cyc();
      key_bit_valid = 1'b0;
   endtask

   task automatic send_key(input logic [7:0] k);
      for (int i = 0; i < 8; i++) send_bit(k[i]);
`ifdef LOCK_KEY_PARITY_EN
      send_bit(^k);
`endif
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int n = 0; n < 30; n++) begin
         if (key_valid) begin
            lat = cyc_n - t_start;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      logic [7:0] k;
      do_reset();
      checks++;
      k = {key_out[7:1], key_valid};
      if ({k, key_ready, busy, err} !== 11'h0) begin
         errors++;
         $display("FAIL reset: out=%h v=%b r=%b b=%b e=%b want all 0",
                  key_out, key_valid, key_ready, busy, err);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [7:0] exp;
      do_reset();
      start_load();
      checks++;
      if (key_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: ready=%b busy=%b want 1 1",
                  key_ready, busy);
      end
      sb.push_back(8'h96);
      send_key(8'h96);
      wait_valid(lat);
      exp = sb.pop_front();
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
      end
      checks++;
      if (key_out !== exp) begin
         errors++;
         $display("FAIL basic_key: got %h want %h", key_out, exp);
      end
      checks++;
      if (early_nz !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: key_out nonzero before commit got %b want 0",
                  early_nz);
      end
      cyc();
      checks++;
      if (busy !== 1'b0 || key_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_locked: busy=%b ready=%b want 0 0",
                  busy, key_ready);
      end
   endtask

   task automatic test_gaps();
      int lat;
      int busy_low;
      logic [7:0] k, exp;
      k = 8'h96;
      busy_low = 0;
      do_reset();
      start_load();
      sb.push_back(k);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            for (int g = 0; g < 3; g++) begin
               cyc();
               if (!busy) busy_low++;
            end
         end
         send_bit(k[i]);
         if (!busy) busy_low++;
      end
`ifdef LOCK_KEY_PARITY_EN
      send_bit(^k);
`endif
      wait_valid(lat);
      exp = sb.pop_front();
      checks++;
      if (key_out !== exp || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL gaps_key: got %h/%b want %h/1", key_out, key_valid, exp);
      end
      checks++;
      if (busy_low !== 0) begin
         errors++;
         $display("FAIL gaps_busy: busy low %0d cycles want 0", busy_low);
      end
      checks++;
      if (err_cnt !== 0) begin
         errors++;
         $display("FAIL gaps_err: err pulses %0d want 0", err_cnt);
      end
   endtask

   task automatic test_restart();
      int lat;
      logic [7:0] exp;
      do_reset();
      start_load();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b0); send_bit(1'b1);
      start_load();
      checks++;
      if (err !== 1'b1 || key_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_pulse: err=%b ready=%b want 1 1",
                  err, key_ready);
      end
      sb.push_back(8'hFF);
      send_key(8'hFF);
      wait_valid(lat);
      exp = sb.pop_front();
      checks++;
      if (key_out !== exp) begin
         errors++;
         $display("FAIL restart_key: got %h want %h", key_out, exp);
      end
      checks++;
      if (err_cnt !== 1) begin
         errors++;
         $display("FAIL restart_errcnt: got %0d want 1", err_cnt);
      end
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL restart_latency: got %0d want %0d", lat, LAT);
      end
   endtask

   task automatic test_locked();
      int lat;
      logic [7:0] exp;
      do_reset();
      start_load();
      sb.push_back(8'h3C);
      send_key(8'h3C);
      wait_valid(lat);
      exp = sb.pop_front();
      checks++;
      if (key_out !== exp) begin
         errors++;
         $display("FAIL locked_commit: got %h want %h", key_out, exp);
      end
      start_load();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL locked_err: got %b want 1", err);
      end
      checks++;
      if (key_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL locked_ready: ready=%b busy=%b want 0 0",
                  key_ready, busy);
      end
      send_key(8'h00);
      cyc(); cyc();
      checks++;
      if (key_out !== exp || key_valid !== 1'b1) begin
         errors++;
         $display("FAIL locked_frozen: got %h/%b want %h/1",
                  key_out, key_valid, exp);
      end
      checks++;
      if (err_cnt !== 1) begin
         errors++;
         $display("FAIL locked_errcnt: got %0d want 1", err_cnt);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (key_out !== 8'h00 || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL locked_reset: got %h/%b want 00/0", key_out, key_valid);
      end
   endtask

   task automatic test_reset_midload();
      int lat;
      logic [7:0] exp;
      do_reset();
      start_load();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({key_out, key_valid, key_ready, busy, err} !== 12'h0) begin
         errors++;
         $display("FAIL midreset_outs: out=%h v=%b r=%b b=%b e=%b want all 0",
                  key_out, key_valid, key_ready, busy, err);
      end
      start_load();
      sb.push_back(8'hA5);
      send_key(8'hA5);
      wait_valid(lat);
      exp = sb.pop_front();
      checks++;
      if (key_out !== exp) begin
         errors++;
         $display("FAIL midreset_key: got %h want %h", key_out, exp);
      end
   endtask

`ifdef LOCK_KEY_PARITY_EN
   task automatic test_parity();
      do_reset();
      start_load();
      for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b0);
      do_reset();
      start_load();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || key_ready !== 1'b0) begin
         errors++;
         $display("FAIL parity_bad: err=%b busy=%b ready=%b want 1 0 0",
                  err, busy, key_ready);
      end
      cyc(); cyc(); cyc();
      checks++;
      if (key_valid !== 1'b0 || key_out !== 8'h00) begin
         errors++;
         $display("FAIL parity_nocommit: got %h/%b want 00/0",
                  key_out, key_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_restart();
      test_locked();
      test_reset_midload();
`ifdef LOCK_KEY_PARITY_EN
      test_parity();
`endif
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
